sync_multi_filt: RTL and testbench
==================================

Name: sync_multi_filt

Overview:
- Parametrised, multi-channel successor to the single-bit reset-high synchronizer.
- Each of WIDTH independent asynchronous inputs passes through a configurable-depth flop chain into the clk domain.
- An optional per-channel glitch filter follows the chain, plus registered-edge rise/fall pulse outputs.
- Used at every asynchronous pin or foreign-domain level signal entering the output-buffer clock domain.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchronizer flop depth. Legal values are 2 to 4; any other value is an elaboration error.
- RST_VAL, {WIDTH{1'b1}}, per-channel reset value of every sync stage and of the filtered output.
- FILTER, 3, stability requirement in clk cycles. 0 means no filter. Legal range is 0 to 255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- async_in  input  WIDTH  asynchronous level inputs, one per channel.
- sync_raw  output  WIDTH  last synchronizer stage, unfiltered.
- sync_out  output  WIDTH  synchronized and filtered level.
- rise_pulse  output  WIDTH  one-cycle high when sync_out[i] goes 0->1.
- fall_pulse  output  WIDTH  one-cycle high when sync_out[i] goes 1->0.

Behaviour:
- Reset: while rst=1, independent of clk:
  - all STAGES chain flops, the sync_out register and the sync_out delay register (sync_d) hold RST_VAL;
  - filter counters are 0;
  - sync_raw=RST_VAL, sync_out=RST_VAL, rise_pulse=0, fall_pulse=0.
- Reset asserted mid-operation discards any in-flight value or partial count immediately.
- No pulse is generated on reset entry or release.
- Chain: stage1<=async_in; stageN<=stage(N-1). sync_raw = stage STAGES.
  - An async_in change settled before edge E0 appears on sync_raw after edge E(STAGES-1), i.e. STAGES edges counting E0.
- FILTER=0: sync_out is a direct wire from sync_raw. No counter is instantiated. Total latency is STAGES edges.
- FILTER>0: per-channel counter, width clog2(FILTER)+1.
  - If sync_raw[i]==sync_out[i]: counter <= 0.
  - If they differ and counter < FILTER-1: counter <= counter+1.
  - If they differ and counter == FILTER-1: sync_out[i] <= sync_raw[i] and counter <= 0.
  - Result: sync_out follows only after sync_raw holds a new value for FILTER consecutive edges. Total latency is STAGES+FILTER edges.
  - A sync_raw deviation shorter than FILTER cycles never reaches sync_out, and its count is discarded on return.
- Pulses are combinational from registers:
  - rise_pulse = sync_out & ~sync_d;
  - fall_pulse = ~sync_out & sync_d;
  - sync_d <= sync_out every edge.
  - Each pulse is high exactly during the first cycle sync_out shows the new level.
  - rise_pulse[i] and fall_pulse[i] are never high together.
- Channels are fully independent. Simultaneous changes on several channels, in either direction, are processed in parallel with identical latency.
- No enable or clear inputs. No metastability modelling is required in RTL.

Test Plan:
1. Reset values: WIDTH=4, STAGES=2, RST_VAL=4'b1010, FILTER=3, async_in=4'b0000, rst pulsed mid-clock -> sync_raw=sync_out=4'b1010 at once, pulses 0. After release, sync_out stays 4'b1010 for 4 edges, then goes to 4'b0000 at the 5th edge (2+3), with fall_pulse=4'b1010 for one cycle.
2. Latency and rise pulse: RST_VAL=0, FILTER=3, async_in[0] 0->1 before edge 0 -> sync_raw[0]=1 after edge 1 and sync_out[0]=1 after edge 4. rise_pulse[0]=1 for exactly the cycle after edge 4, with other channels quiet.
3. Glitch rejection: FILTER=3, async_in[1] high for 2 clk cycles then low -> sync_raw[1] shows the 2-cycle pulse, sync_out[1] stays 0, both pulses stay 0. A 3-cycle pulse -> sync_out[1] high for 3 cycles, with one rise pulse and one fall pulse.
4. Mid-operation reset: FILTER=3, async_in[2] 0->1, rst asserted for 1 cycle after edge 3 (counter nonzero) -> sync_out[2] is RST_VAL immediately and no pulse fires. After release the full 5-edge latency restarts from the first post-reset edge.
5. Simultaneous channels: async_in 4'b0101->4'b1010 in one cycle, FILTER=3 -> sync_out changes all bits on the same edge. rise_pulse=4'b1010 and fall_pulse=4'b0101 in the same cycle.
6. No-filter config: STAGES=3, FILTER=0, random async_in for 1000 cycles -> sync_out==sync_raw==async_in delayed 3 edges on every cycle. Pulses match edges of the reference model.

Source files
------------

// File: rtl/sync_multi_filt.sv
// Multi-channel synchronizer: STAGES-deep flop chain per channel, optional glitch filter, rise/fall pulses.
// Latency is STAGES edges, plus FILTER edges when the filter is enabled. There is no backpressure.
module sync_multi_filt #(
  parameter int               WIDTH   = 4,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}},
  parameter int               FILTER  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_raw,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_multi_filt: STAGES must be in 2..4");
  end
  if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
    $error("sync_multi_filt: FILTER must be in 0..255");
  end

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= RST_VAL;
    end else begin
      chain[0] <= async_in;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign sync_raw = chain[STAGES-1];

  if (FILTER == 0) begin : g_nofilt
    assign sync_out = sync_raw;
  end else begin : g_filt
    localparam int CW = $clog2(FILTER) + 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] out_q;

    // A channel's count restarts whenever its raw level returns to the filtered level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= RST_VAL;
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_raw[i] == out_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == LAST) begin
            out_q[i] <= sync_raw[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end

    assign sync_out = out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_d <= RST_VAL;
    else     sync_d <= sync_out;
  end

  assign rise_pulse = sync_out & ~sync_d;
  assign fall_pulse = ~sync_out & sync_d;

endmodule

// File: tb/tb_sync_multi_filt.sv
// Bench for sync_multi_filt: four configurations share one stimulus and are checked against a history-based model.
module tb_sync_multi_filt;
  localparam int N = 4;
  localparam int ST [N] = '{2, 2, 3, 4};
  localparam int FL [N] = '{3, 3, 0, 1};
  localparam logic [3:0] RV [N] = '{4'b1010, 4'b0000, 4'b0000, 4'b0110};

  logic       clk;
  logic       rst;
  logic [3:0] async_in;
  logic [3:0] raw_v  [N];
  logic [3:0] out_v  [N];
  logic [3:0] rise_v [N];
  logic [3:0] fall_v [N];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  for (genvar k = 0; k < N; k++) begin : g_dut
    sync_multi_filt #(
      .WIDTH(4), .STAGES(ST[k]), .RST_VAL(RV[k]), .FILTER(FL[k])
    ) u_dut (
      .clk(clk), .rst(rst), .async_in(async_in),
      .sync_raw(raw_v[k]), .sync_out(out_v[k]),
      .rise_pulse(rise_v[k]), .fall_pulse(fall_v[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the raw level is the input sampled STAGES edges ago; the filtered level flips only when
  // the last FILTER raw samples since reset all disagree with it.
  logic [3:0] in_hist [$];
  logic [3:0] m_out [N];
  logic [3:0] m_prev [N];
  logic [3:0] m_raw [N];

  function automatic logic [3:0] raw_at(input int k, input int n);
    if (n >= ST[k]) return in_hist[n - ST[k]];
    return RV[k];
  endfunction

  task automatic model_reset();
    in_hist.delete();
    for (int k = 0; k < N; k++) begin
      m_out[k]  = RV[k];
      m_prev[k] = RV[k];
      m_raw[k]  = RV[k];
    end
  endtask

  task automatic model_edge();
    int n;
    logic [3:0] r;
    in_hist.push_back(async_in);
    n = in_hist.size();
    for (int k = 0; k < N; k++) begin
      m_prev[k] = m_out[k];
      m_raw[k]  = raw_at(k, n);
      if (FL[k] == 0) begin
        m_out[k] = m_raw[k];
      end else if (n >= FL[k]) begin
        for (int i = 0; i < 4; i++) begin
          bit flip;
          flip = 1'b1;
          for (int e = n - FL[k] + 1; e <= n; e++) begin
            r = raw_at(k, e - 1);
            if (r[i] == m_out[k][i]) flip = 1'b0;
          end
          if (flip) m_out[k][i] = ~m_out[k][i];
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_edge();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("dut%0d.sync_raw", k), 32'(raw_v[k]), 32'(m_raw[k]));
        check($sformatf("dut%0d.sync_out", k), 32'(out_v[k]), 32'(m_out[k]));
        check($sformatf("dut%0d.rise_pulse", k), 32'(rise_v[k]), 32'(m_out[k] & ~m_prev[k]));
        check($sformatf("dut%0d.fall_pulse", k), 32'(fall_v[k]), 32'(~m_out[k] & m_prev[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_ch1(input int len, output int nraw, output int nout,
                           output int nrise, output int nfall);
    nraw = 0; nout = 0; nrise = 0; nfall = 0;
    async_in[1] = 1'b1;
    for (int s = 0; s < 14; s++) begin
      if (s == len) async_in[1] = 1'b0;
      step();
      nraw  += int'(raw_v[1][1]);
      nout  += int'(out_v[1][1]);
      nrise += int'(rise_v[1][1]);
      nfall += int'(fall_v[1][1]);
    end
  endtask

  initial begin
    int nraw, nout, nrise, nfall;
    logic [3:0] vq [$];
    logic [3:0] mask;

    rst = 1'b0;
    async_in = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset applied between edges takes effect at once.
    #2 rst = 1'b1;
    #1;
    check("t1 reset sync_raw", 32'(raw_v[0]), 32'h0000000a);
    check("t1 reset sync_out", 32'(out_v[0]), 32'h0000000a);
    check("t1 reset rise", 32'(rise_v[0]), 32'h0);
    check("t1 reset fall", 32'(fall_v[0]), 32'h0);
    check("t1 reset sync_out dut3", 32'(out_v[3]), 32'h00000006);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("t1 hold edge%0d", e), 32'(out_v[0]), 32'h0000000a);
    end
    step();
    check("t1 sync_out edge5", 32'(out_v[0]), 32'h0);
    check("t1 fall edge5", 32'(fall_v[0]), 32'h0000000a);

    // Single-channel latency on the zero-reset instance.
    step();
    async_in[0] = 1'b1;
    step();
    check("t2 raw after E0", 32'(raw_v[1]), 32'h0);
    step();
    check("t2 raw after E1", 32'(raw_v[1]), 32'h1);
    step();
    step();
    check("t2 out after E3", 32'(out_v[1]), 32'h0);
    step();
    check("t2 out after E4", 32'(out_v[1]), 32'h1);
    check("t2 rise after E4", 32'(rise_v[1]), 32'h1);
    step();
    check("t2 rise after E5", 32'(rise_v[1]), 32'h0);

    // Glitch rejection and a just-long-enough pulse on channel 1.
    pulse_ch1(2, nraw, nout, nrise, nfall);
    check("t3 2cyc raw count", 32'(nraw), 32'd2);
    check("t3 2cyc out count", 32'(nout), 32'd0);
    check("t3 2cyc rise count", 32'(nrise), 32'd0);
    check("t3 2cyc fall count", 32'(nfall), 32'd0);
    pulse_ch1(3, nraw, nout, nrise, nfall);
    check("t3 3cyc out count", 32'(nout), 32'd3);
    check("t3 3cyc rise count", 32'(nrise), 32'd1);
    check("t3 3cyc fall count", 32'(nfall), 32'd1);

    // Reset while a count is in flight.
    async_in[2] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("t4 reset out dut1", 32'(out_v[1]), 32'h0);
    check("t4 reset rise dut1", 32'(rise_v[1]), 32'h0);
    check("t4 reset fall dut1", 32'(fall_v[1]), 32'h0);
    check("t4 reset out dut0", 32'(out_v[0]), 32'h0000000a);
    check("t4 reset fall dut0", 32'(fall_v[0]), 32'h0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("t4 hold edge%0d", e), 32'(out_v[1]), 32'h0);
    end
    step();
    check("t4 out edge5", 32'(out_v[1]), 32'h5);
    check("t4 rise edge5", 32'(rise_v[1]), 32'h5);

    // All channels change together in both directions.
    repeat (3) step();
    async_in = 4'b1010;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("t5 hold edge%0d", e), 32'(out_v[1]), 32'h5);
    end
    step();
    check("t5 out edge5", 32'(out_v[1]), 32'ha);
    check("t5 rise edge5", 32'(rise_v[1]), 32'ha);
    check("t5 fall edge5", 32'(fall_v[1]), 32'h5);

    // Random traffic: wide toggling, then sparse toggling to exercise the filters.
    for (int j = 0; j < 1000; j++) begin
      if (j < 500) begin
        async_in = 4'($urandom);
      end else begin
        for (int i = 0; i < 4; i++) mask[i] = ($urandom_range(3) == 0);
        async_in = async_in ^ mask;
      end
      vq.push_back(async_in);
      step();
      if (j >= 2) begin
        check("t6 nofilt sync_out", 32'(out_v[2]), 32'(vq[j-2]));
        check("t6 nofilt sync_raw", 32'(raw_v[2]), 32'(vq[j-2]));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
